tcp_rx_op_queue: RTL

//  Receive-side queue between the TCP RX header parser and tcp_controller.

---
 rtl/tcp_rx_op_queue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tcp_rx_op_queue.sv
// Stages parsed TCP RX headers, commits/discards on packet verdict, queues local-port descriptors.
// Latency: a committed descriptor is visible on the head outputs one cycle after pkt_ok_i.
// Backpressure: none upstream; a full queue, a foreign port or a bad packet drops and counts.
module tcp_rx_op_queue #(
  parameter int          DEPTH_LOG2 = 2,
  parameter logic [15:0] LOCAL_PORT = 16'hF718
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hdr_wr_i,
  input  logic [15:0]           hdr_src_port_i,
  input  logic [15:0]           hdr_dst_port_i,
  input  logic [5:0]            hdr_flags_i,
  input  logic [95:0]           hdr_options_i,
  input  logic [31:0]           hdr_seq_num_i,
  input  logic [31:0]           hdr_ack_num_i,
  input  logic [15:0]           hdr_data_len_i,
  input  logic [15:0]           hdr_window_i,
  input  logic                  pkt_ok_i,
  input  logic                  pkt_bad_i,
  output logic                  tcp_op_rcv_o,
  output logic [15:0]           tcp_source_port_o,
  output logic [15:0]           tcp_dest_port_o,
  output logic [5:0]            tcp_flags_o,
  output logic [95:0]           tcp_options_o,
  output logic [31:0]           tcp_seq_num_o,
  output logic [31:0]           tcp_ack_num_o,
  output logic [15:0]           tcp_data_len_o,
  output logic [15:0]           tcp_window_o,
  input  logic                  tcp_op_rcv_rd_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic [15:0]           drop_cnt_o
);

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [5:0]  flags;
    logic [95:0] options;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [15:0] len;
    logic [15:0] win;
  } desc_t;

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] FULL_LVL = LVL_ONE << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  desc_t                 mem [DEPTH];
  desc_t                 stg;
  desc_t                 head;
  logic                  stg_valid;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;

  logic end_any;
  logic commit;
  logic pop;
  logic space;
  logic push;
  logic drop;

  // Verdict decode: a simultaneous ok+bad is a bad packet; end pulses act on the old staging.
  always_comb begin
    end_any = pkt_ok_i | pkt_bad_i;
    commit  = stg_valid & pkt_ok_i & ~pkt_bad_i;
    pop     = tcp_op_rcv_rd_i & (level != '0);
    space   = (level < FULL_LVL) | ((level == FULL_LVL) & pop);
    push    = commit & (stg.dst == LOCAL_PORT) & space;
    drop    = (stg_valid & pkt_bad_i)
            | (commit & ~push)
            | (stg_valid & hdr_wr_i & ~end_any);
  end

  // Staging register: a new header always loads; an end pulse alone invalidates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= 1'b0;
      stg       <= '0;
    end else if (hdr_wr_i) begin
      stg_valid <= 1'b1;
      stg       <= '{src: hdr_src_port_i, dst: hdr_dst_port_i, flags: hdr_flags_i,
                     options: hdr_options_i, seq: hdr_seq_num_i, ack: hdr_ack_num_i,
                     len: hdr_data_len_i, win: hdr_window_i};
    end else if (end_any) begin
      stg_valid <= 1'b0;
    end
  end

  // Descriptor storage; contents are only observable while the entry is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stg;
  end

  // Pointers wrap modulo DEPTH; level is kept separately so full and empty are unambiguous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      level <= level + LVL_ONE;
      else if (pop && !push) level <= level - LVL_ONE;
    end
  end

  // Saturating drop counter, at most one increment per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_o <= '0;
    end else if (drop && drop_cnt_o != 16'hFFFF) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  // Head is a combinational read, forced to zero when empty so reset shows all-zero fields.
  always_comb begin
    head = (level != '0) ? mem[rd_ptr] : '0;
  end

  assign tcp_op_rcv_o      = (level != '0);
  assign level_o           = level;
  assign tcp_source_port_o = head.src;
  assign tcp_dest_port_o   = head.dst;
  assign tcp_flags_o       = head.flags;
  assign tcp_options_o     = head.options;
  assign tcp_seq_num_o     = head.seq;
  assign tcp_ack_num_o     = head.ack;
  assign tcp_data_len_o    = head.len;
  assign tcp_window_o      = head.win;

endmodule
